instr_fetch: RTL and testbench

Fetch stage sitting directly downstream of the program counter. Holds the instruction memory, registers the instruction addressed by the current PC, and presents it with a valid flag to decode. Suppresses wrong-path fetches after a taken branch, detects the halt instruction, and reports run completion plus a run-length cycle count. Memory is loaded through a write port while the core is idle or done.

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: instruction memory plus registered instruction/PC/valid toward decode.
// Tracks IDLE/RUN/DONE, suppresses wrong-path words, detects halt, counts run cycles.
module instr_fetch #(
  parameter int                   PC_W    = 9,
  parameter int                   INSTR_W = 9,
  parameter logic [INSTR_W-1:0]   HALT_OP = 9'h1FF,
  parameter int                   CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  input  logic               flush,
  input  logic               ld_en,
  input  logic [PC_W-1:0]    ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               done,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [INSTR_W-1:0] mem [0:(2**PC_W)-1];
  state_t             state_r;
  state_t             next_state_s;
  logic               halt_seen_s;
  logic               busy_s;

  // A halt only counts once it has been presented as a valid instruction.
  assign halt_seen_s = instr_valid && (instr == HALT_OP);

  // Loader write port; locked out while running so the program cannot change under fetch.
  always_ff @(posedge clk) begin
    if (ld_en && (state_r != RUN)) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start outranks halt so a restart in RUN stays in RUN.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      RUN: begin
        if (start)            next_state_s = RUN;
        else if (halt_seen_s) next_state_s = DONE;
        else                  next_state_s = RUN;
      end
      DONE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_s = 1'b0;
    if (state_r == RUN) busy_s = 1'b1;
    else                busy_s = 1'b0;
  end

  assign busy = busy_s;

  // Fetch register: the word is always captured in RUN, validity decides if decode uses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= {INSTR_W{1'b0}};
      instr_pc    <= {PC_W{1'b0}};
      instr_valid <= 1'b0;
    end else if (state_r == RUN) begin
      instr       <= mem[pc];
      instr_pc    <= pc;
      instr_valid <= !(start || flush || halt_seen_s);
    end else begin
      instr_valid <= 1'b0;
    end
  end

  // Done flag and saturating run-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      done        <= 1'b0;
      cycle_count <= {CNT_W{1'b0}};
    end else if (start) begin
      done        <= 1'b0;
      cycle_count <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      if (halt_seen_s) done <= 1'b1;
      else             done <= done;
      if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
      else                        cycle_count <= cycle_count;
    end else begin
      done        <= done;
      cycle_count <= cycle_count;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the straight-line and branch runs,
// hand sequences for loader lockout, mid-run reset, restart and counter saturation.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  pc;
  logic        flush;
  logic        ld_en;
  logic [8:0]  ld_addr;
  logic [8:0]  ld_data;
  logic [8:0]  instr, s_instr;
  logic [8:0]  instr_pc, s_instr_pc;
  logic        instr_valid, s_instr_valid;
  logic        done, s_done;
  logic        busy, s_busy;
  logic [15:0] cycle_count;
  logic [3:0]  s_cycle_count;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .done(done), .busy(busy), .cycle_count(cycle_count)
  );

  instr_fetch #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr(s_instr), .instr_pc(s_instr_pc), .instr_valid(s_instr_valid),
    .done(s_done), .busy(s_busy), .cycle_count(s_cycle_count)
  );

  typedef struct {
    logic        st;
    logic        fl;
    logic [8:0]  p;
    logic [8:0]  e_instr;
    logic [8:0]  e_pc;
    logic        e_valid;
    logic        e_done;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(input logic st, input logic fl, input logic [8:0] p,
                              input logic [8:0] ei, input logic [8:0] ep, input logic ev,
                              input logic ed, input logic eb, input logic [15:0] ec);
    vec_t r;
    r.st = st; r.fl = fl; r.p = p;
    r.e_instr = ei; r.e_pc = ep; r.e_valid = ev;
    r.e_done = ed; r.e_busy = eb; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic st, input logic fl, input logic [8:0] p);
    start = st; flush = fl; pc = p;
    tick();
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic load(input logic [8:0] a, input logic [8:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] ei, input logic [8:0] ep,
                            input logic ev, input logic ed, input logic eb, input logic [15:0] ec);
    chk({tag, ".instr"}, 32'(instr), 32'(ei));
    chk({tag, ".instr_pc"}, 32'(instr_pc), 32'(ep));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(ev));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(ec));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; pc = 9'd0;
    ld_en = 1'b0; ld_addr = 9'd0; ld_data = 9'd0;
    tick();
    tick();
    expect_out("reset", 9'h000, 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("reset.sat_cnt", 32'(s_cycle_count), 32'd0);
    reset = 1'b0;

    load(9'd0, 9'h001); load(9'd1, 9'h002); load(9'd2, 9'h003); load(9'd3, 9'h1FF);
    load(9'd4, 9'h044); load(9'd5, 9'h1FF); load(9'd6, 9'h000);
    load(9'd8, 9'h055); load(9'd9, 9'h1FF); load(9'd10, 9'h000);
    expect_out("idle_after_load", 9'h000, 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);

    // straight-line run to halt
    vt[0]  = mk(1'b1, 1'b0, 9'd0,  9'h000, 9'd0,  1'b0, 1'b0, 1'b1, 16'd0);
    vt[1]  = mk(1'b0, 1'b0, 9'd0,  9'h001, 9'd0,  1'b1, 1'b0, 1'b1, 16'd1);
    vt[2]  = mk(1'b0, 1'b0, 9'd1,  9'h002, 9'd1,  1'b1, 1'b0, 1'b1, 16'd2);
    vt[3]  = mk(1'b0, 1'b0, 9'd2,  9'h003, 9'd2,  1'b1, 1'b0, 1'b1, 16'd3);
    vt[4]  = mk(1'b0, 1'b0, 9'd3,  9'h1FF, 9'd3,  1'b1, 1'b0, 1'b1, 16'd4);
    vt[5]  = mk(1'b0, 1'b0, 9'd4,  9'h044, 9'd4,  1'b0, 1'b1, 1'b0, 16'd5);
    vt[6]  = mk(1'b0, 1'b0, 9'd5,  9'h044, 9'd4,  1'b0, 1'b1, 1'b0, 16'd5);
    // branch at 1 to 8, restarted from DONE
    vt[7]  = mk(1'b1, 1'b0, 9'd5,  9'h044, 9'd4,  1'b0, 1'b0, 1'b1, 16'd0);
    vt[8]  = mk(1'b0, 1'b0, 9'd0,  9'h001, 9'd0,  1'b1, 1'b0, 1'b1, 16'd1);
    vt[9]  = mk(1'b0, 1'b0, 9'd1,  9'h002, 9'd1,  1'b1, 1'b0, 1'b1, 16'd2);
    vt[10] = mk(1'b0, 1'b1, 9'd2,  9'h003, 9'd2,  1'b0, 1'b0, 1'b1, 16'd3);
    vt[11] = mk(1'b0, 1'b0, 9'd8,  9'h055, 9'd8,  1'b1, 1'b0, 1'b1, 16'd4);
    vt[12] = mk(1'b0, 1'b0, 9'd9,  9'h1FF, 9'd9,  1'b1, 1'b0, 1'b1, 16'd5);
    vt[13] = mk(1'b0, 1'b0, 9'd10, 9'h000, 9'd10, 1'b0, 1'b1, 1'b0, 16'd6);

    for (int i = 0; i < 14; i++) begin
      step(vt[i].st, vt[i].fl, vt[i].p);
      expect_out($sformatf("vec%0d", i), vt[i].e_instr, vt[i].e_pc, vt[i].e_valid,
                 vt[i].e_done, vt[i].e_busy, vt[i].e_cnt);
    end

    // loader is ignored in RUN, honoured in DONE
    step(1'b1, 1'b0, 9'd0);
    ld_en = 1'b1; ld_addr = 9'd0; ld_data = 9'h0AA;
    step(1'b0, 1'b0, 9'd0);
    ld_en = 1'b0;
    expect_out("ld_run_same", 9'h001, 9'd0, 1'b1, 1'b0, 1'b1, 16'd1);
    step(1'b0, 1'b0, 9'd0);
    chk("ld_run_ignored.instr", 32'(instr), 32'h001);
    step(1'b0, 1'b0, 9'd3);
    step(1'b0, 1'b0, 9'd4);
    expect_out("ld_run_halt", 9'h044, 9'd4, 1'b0, 1'b1, 1'b0, 16'd4);
    load(9'd0, 9'h0AA);
    step(1'b1, 1'b0, 9'd0);
    step(1'b0, 1'b0, 9'd0);
    expect_out("ld_done_taken", 9'h0AA, 9'd0, 1'b1, 1'b0, 1'b1, 16'd1);
    step(1'b0, 1'b0, 9'd3);
    step(1'b0, 1'b0, 9'd4);
    chk("ld_done_run.done", 32'(done), 32'd1);
    load(9'd0, 9'h001);

    // reset in the third RUN cycle
    step(1'b1, 1'b0, 9'd0);
    step(1'b0, 1'b0, 9'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 9'd1);
    reset = 1'b0;
    expect_out("midrun_reset", 9'h000, 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 9'd2);
    expect_out("post_reset_idle", 9'h000, 9'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b1, 1'b0, 9'd0);
    step(1'b0, 1'b0, 9'd0);
    expect_out("rerun0", 9'h001, 9'd0, 1'b1, 1'b0, 1'b1, 16'd1);
    step(1'b0, 1'b0, 9'd1);
    step(1'b0, 1'b0, 9'd2);
    step(1'b0, 1'b0, 9'd3);
    expect_out("rerun3", 9'h1FF, 9'd3, 1'b1, 1'b0, 1'b1, 16'd4);
    step(1'b0, 1'b0, 9'd4);
    expect_out("rerun_done", 9'h044, 9'd4, 1'b0, 1'b1, 1'b0, 16'd5);

    // start while running, restart at 4
    step(1'b1, 1'b0, 9'd0);
    step(1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b0, 9'd1);
    expect_out("restart_pre", 9'h002, 9'd1, 1'b1, 1'b0, 1'b1, 16'd2);
    step(1'b1, 1'b0, 9'd2);
    expect_out("restart_edge", 9'h003, 9'd2, 1'b0, 1'b0, 1'b1, 16'd0);
    step(1'b0, 1'b0, 9'd4);
    expect_out("restart_first", 9'h044, 9'd4, 1'b1, 1'b0, 1'b1, 16'd1);
    step(1'b0, 1'b0, 9'd5);
    step(1'b0, 1'b0, 9'd6);
    expect_out("restart_done", 9'h000, 9'd6, 1'b0, 1'b1, 1'b0, 16'd3);

    // long loop: the 4-bit counter saturates, the 16-bit one does not
    step(1'b1, 1'b0, 9'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 9'd0);
      if (i == 13) chk("sat_at14", 32'(s_cycle_count), 32'd14);
      if (i == 15) chk("sat_at16", 32'(s_cycle_count), 32'd15);
    end
    step(1'b0, 1'b0, 9'd3);
    step(1'b0, 1'b0, 9'd4);
    chk("sat.done", 32'(s_done), 32'd1);
    chk("sat.cnt_done", 32'(s_cycle_count), 32'd15);
    chk("wide.cnt_done", 32'(cycle_count), 32'd22);
    step(1'b0, 1'b0, 9'd5);
    chk("sat.cnt_hold", 32'(s_cycle_count), 32'd15);
    chk("sat.busy", 32'(s_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
